// File: rtl/pulse_period_meter.sv
// Measures the spacing of clk-synchronous events on pulse_in, flags a stable
// (locked) stream, and reports loss of the stream when the gap exceeds a limit.
module pulse_period_meter #(
  parameter int unsigned LOCK_COUNT = 4,
  localparam int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] timeout_limit,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] LOCK_TGT = STREAK_W'(LOCK_COUNT);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [CNT_W-1:0]    period_d;
  logic [STREAK_W-1:0] streak, streak_d;
  logic                valid_d;
  logic                locked_d;
  logic                timeout_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and datapath decode; an event always wins over a timeout
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    period_d  = period_out;
    streak_d  = streak;
    valid_d   = 1'b0;
    locked_d  = locked;
    timeout_d = 1'b0;

    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end
      end

      MEASURE: begin
        if (pulse_in) begin
          period_d = cnt;
          valid_d  = 1'b1;
          cnt_d    = '0;
          // streak==0 means no measurement held since IDLE, so restart at 1
          if ((streak == '0) || (cnt != period_out)) begin
            streak_d = STREAK_W'(1);
          end else if (streak < LOCK_TGT) begin
            streak_d = streak + STREAK_W'(1);
          end
          locked_d = (streak_d >= LOCK_TGT);
        end else if (cnt == timeout_limit) begin
          state_d   = IDLE;
          cnt_d     = '0;
          streak_d  = '0;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter, streak and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      streak       <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      streak       <= streak_d;
      period_out   <= period_d;
      period_valid <= valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an event-time model.
module tb_pulse_period_meter;

  localparam int unsigned LOCK = 4;

  logic        clk;
  logic        reset;
  logic        pulse_in;
  logic [31:0] timeout_limit;
  logic [31:0] period_out;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  pulse_period_meter #(.LOCK_COUNT(LOCK)) dut (
    .clk           (clk),
    .reset         (reset),
    .pulse_in      (pulse_in),
    .timeout_limit (timeout_limit),
    .period_out    (period_out),
    .period_valid  (period_valid),
    .locked        (locked),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works from absolute event times and a history of periods
  longint      cyc = 0;
  longint      last_evt = 0;
  longint      elapsed;
  bit          m_armed = 1'b0;
  logic [31:0] hist[$];
  logic [31:0] exp_period = '0;
  logic        exp_valid = 1'b0;
  logic        exp_locked = 1'b0;
  logic        exp_timeout = 1'b0;

  function automatic bit hist_locked();
    if (hist.size() < LOCK) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  always begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_armed     = 1'b0;
      hist.delete();
      exp_period  = '0;
      exp_valid   = 1'b0;
      exp_locked  = 1'b0;
      exp_timeout = 1'b0;
    end else begin
      cyc++;
      exp_valid   = 1'b0;
      exp_timeout = 1'b0;
      if (!m_armed) begin
        if (pulse_in) begin
          m_armed  = 1'b1;
          last_evt = cyc;
        end
      end else begin
        elapsed = cyc - last_evt - 1;
        if (pulse_in) begin
          exp_period = 32'(elapsed);
          exp_valid  = 1'b1;
          last_evt   = cyc;
          hist.push_back(32'(elapsed));
          if (hist.size() > LOCK) void'(hist.pop_front());
          exp_locked = hist_locked();
        end else if (elapsed == longint'(timeout_limit)) begin
          exp_timeout = 1'b1;
          exp_locked  = 1'b0;
          m_armed     = 1'b0;
          hist.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("period_out", period_out, exp_period);
      chk("period_valid", 32'(period_valid), 32'(exp_valid));
      chk("locked", 32'(locked), 32'(exp_locked));
      chk("timeout", 32'(timeout), 32'(exp_timeout));
    end
  end

  task automatic drive(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] per, input logic v,
                         input logic lk, input logic to);
    chk({tag, ".period_out"}, period_out, per);
    chk({tag, ".period_valid"}, 32'(period_valid), 32'(v));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    int mode;
    int per;
    logic p;

    reset         = 1'b1;
    pulse_in      = 1'b0;
    timeout_limit = 32'd100;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);

    // Event in the very first cycle after release starts the measurement
    reset = 1'b0;
    drive(1'b1);
    chk_out("start", 32'd0, 1'b0, 1'b0, 1'b0);

    // Events every 6 cycles: period 5, lock on the 4th strobe
    for (int k = 1; k <= 6; k++) begin
      repeat (5) drive(1'b0);
      drive(1'b1);
      chk_out("p5", 32'd5, 1'b1, (k >= 4), 1'b0);
    end

    // One 9-cycle interval drops lock immediately; relock after 4 strobes
    for (int k = 1; k <= 5; k++) begin
      repeat (8) drive(1'b0);
      drive(1'b1);
      chk_out("p8", 32'd8, 1'b1, (k >= 4), 1'b0);
    end

    // Stream stops with limit 10: timeout exactly at cnt==10, period held
    timeout_limit = 32'd10;
    repeat (10) drive(1'b0);
    chk_out("pre_to", 32'd8, 1'b0, 1'b1, 1'b0);
    drive(1'b0);
    chk_out("to", 32'd8, 1'b0, 1'b0, 1'b1);
    drive(1'b0);
    chk_out("post_to", 32'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b1);
    chk_out("restart", 32'd8, 1'b0, 1'b0, 1'b0);

    // Event coincides with cnt==limit: measurement wins
    repeat (10) drive(1'b0);
    drive(1'b1);
    chk_out("edge10", 32'd10, 1'b1, 1'b0, 1'b0);

    // Continuous high: period 0 every cycle
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1);
      chk_out("p0", 32'd0, 1'b1, (k >= 4), 1'b0);
    end

    // Limit 0: period-0 stream still measured, any gap times out
    timeout_limit = 32'd0;
    drive(1'b1);
    chk_out("lim0_evt", 32'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0);
    chk_out("lim0_to", 32'd0, 1'b0, 1'b0, 1'b1);

    // Limit lowered mid-count takes effect on the next comparison
    timeout_limit = 32'd50;
    drive(1'b1);
    repeat (5) drive(1'b0);
    timeout_limit = 32'd7;
    repeat (2) drive(1'b0);
    chk("lim_chg.early", 32'(timeout), 32'd0);
    drive(1'b0);
    chk("lim_chg.to", 32'(timeout), 32'd1);

    // Lock at period 3, then asynchronous reset between edges mid-count
    timeout_limit = 32'd100;
    drive(1'b1);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) drive(1'b0);
      drive(1'b1);
    end
    chk_out("p3", 32'd3, 1'b1, 1'b1, 1'b0);
    repeat (2) drive(1'b0);
    #1 reset = 1'b1;
    #1;
    chk_out("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1);
    chk_out("rst_start", 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b0);
    drive(1'b1);
    chk_out("rst_p2", 32'd2, 1'b1, 1'b0, 1'b0);

    // Randomized traffic; the limit is only lowered while disarmed
    for (int seg = 0; seg < 50; seg++) begin
      mode = int'($urandom_range(0, 3));
      per  = int'($urandom_range(1, 8));
      if (!m_armed) timeout_limit = 32'($urandom_range(0, 12));
      else          timeout_limit = timeout_limit + 32'($urandom_range(0, 5));
      for (int k = 0; k < 50; k++) begin
        case (mode)
          0:       p = ((k % per) == 0);
          1:       p = ($urandom_range(0, 2) == 0);
          2:       p = ((k % per) == 0) && ($urandom_range(0, 9) != 0);
          default: p = ($urandom_range(0, 24) == 0);
        endcase
        drive(p);
        if ($urandom_range(0, 399) == 0) begin
          #1 reset = 1'b1;
          @(posedge clk);
          #1 reset = 1'b0;
        end
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
